// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: paced byte reader for a 16x8 async FIFO, packing bytes into wide valid/ready words.
// Optional read-error counter is built only when FIFO_RD_PACKER_ERR_CNT_EN is defined.
module fifo_rd_packer #(
   parameter int unsigned BYTES_PER_WORD = 4
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        fifo_empty_i,
   input  logic [7:0]                  fifo_rdata_i,
   input  logic                        fifo_rd_error_i,
   output logic                        fifo_rd_en_o,
   input  logic                        flush_i,
   output logic [8*BYTES_PER_WORD-1:0] out_data_o,
   output logic [BYTES_PER_WORD-1:0]   out_keep_o,
   output logic                        out_valid_o,
   input  logic                        out_ready_i,
   output logic [15:0]                 err_cnt_o
);

   localparam int unsigned OUT_W = 8 * BYTES_PER_WORD;
   localparam int unsigned CNT_W = $clog2(BYTES_PER_WORD + 1);

   typedef enum logic [1:0] {S_CHECK, S_READ, S_CAPT, S_SETTLE} state_t;

   state_t           state;
   logic [CNT_W-1:0] byte_cnt;
   logic [OUT_W-1:0] acc;
   logic             flush_pend;

   logic                      acc_full_c;
   logic                      reg_free_c;
   logic                      xfer_c;
   logic [BYTES_PER_WORD-1:0] part_keep_c;

   assign acc_full_c = (byte_cnt == CNT_W'(BYTES_PER_WORD));
   assign xfer_c     = out_valid_o & out_ready_i;
   assign reg_free_c = ~out_valid_o | out_ready_i;

   // Keep mask for a partial word: one bit per byte already captured.
   always_comb begin
      part_keep_c = '0;
      for (int unsigned k = 0; k < BYTES_PER_WORD; k++) begin
         part_keep_c[k] = (CNT_W'(k) < byte_cnt);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state        <= S_CHECK;
         byte_cnt     <= '0;
         acc          <= '0;
         flush_pend   <= 1'b0;
         fifo_rd_en_o <= 1'b0;
         out_data_o   <= '0;
         out_keep_o   <= '0;
         out_valid_o  <= 1'b0;
      end else begin
         fifo_rd_en_o <= 1'b0;
         if (xfer_c) begin
            out_valid_o <= 1'b0;
         end
         if (flush_i) begin
            flush_pend <= 1'b1;
         end

         // Read pacing: one pop per READ, then CAPT and SETTLE before the empty flag is trusted again.
         case (state)
            S_CHECK: begin
               if (!acc_full_c && !fifo_empty_i) begin
                  state        <= S_READ;
                  fifo_rd_en_o <= 1'b1;
               end
            end
            S_READ: begin
               state <= S_CAPT;
            end
            S_CAPT: begin
               for (int unsigned k = 0; k < BYTES_PER_WORD; k++) begin
                  if (byte_cnt == CNT_W'(k)) begin
                     acc[8*k +: 8] <= fifo_rdata_i;
                  end
               end
               byte_cnt <= byte_cnt + CNT_W'(1);
               state    <= S_SETTLE;
            end
            S_SETTLE: begin
               state <= S_CHECK;
            end
            default: begin
               state <= S_CHECK;
            end
         endcase

         // A full word always takes precedence over a pending flush.
         if (acc_full_c && reg_free_c) begin
            out_data_o  <= acc;
            out_keep_o  <= '1;
            out_valid_o <= 1'b1;
            byte_cnt    <= '0;
            acc         <= '0;
            flush_pend  <= flush_i;
         end else if ((state == S_CHECK) && flush_pend && !acc_full_c) begin
            if (byte_cnt == '0) begin
               flush_pend <= flush_i;
            end else if (reg_free_c) begin
               out_data_o  <= acc;
               out_keep_o  <= part_keep_c;
               out_valid_o <= 1'b1;
               byte_cnt    <= '0;
               acc         <= '0;
               flush_pend  <= flush_i;
            end
         end
      end
   end

`ifdef FIFO_RD_PACKER_ERR_CNT_EN
   // Saturating count of cycles with the FIFO read-error flag raised.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         err_cnt_o <= '0;
      end else if (fifo_rd_error_i && (err_cnt_o != 16'hFFFF)) begin
         err_cnt_o <= err_cnt_o + 16'd1;
      end
   end
`else
   logic unused_rd_error;
   assign unused_rd_error = fifo_rd_error_i;
   assign err_cnt_o       = 16'h0;
`endif

endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb_fifo_rd_packer: FIFO read-port model plus output scoreboard for fifo_rd_packer (BYTES_PER_WORD=4).
module tb_fifo_rd_packer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        fifo_empty = 1'b1;
   logic [7:0]  fifo_rdata = 8'h00;
   logic        fifo_rd_error = 1'b0;
   logic        fifo_rd_en;
   logic        flush = 1'b0;
   logic [31:0] out_data;
   logic [3:0]  out_keep;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] err_cnt;

   int checks = 0;
   int errors = 0;

   logic [7:0]  fifo_q[$];
   logic [35:0] exp_q[$];
   int          rd_times[$];
   int          cyc = 0;
   int          rd_cnt = 0;
   int          empty_reads = 0;
   int          spacing_viol = 0;
   int          last_rd = -100;
   int          words_seen = 0;

   fifo_rd_packer #(.BYTES_PER_WORD(4)) dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .fifo_empty_i    (fifo_empty),
      .fifo_rdata_i    (fifo_rdata),
      .fifo_rd_error_i (fifo_rd_error),
      .fifo_rd_en_o    (fifo_rd_en),
      .flush_i         (flush),
      .out_data_o      (out_data),
      .out_keep_o      (out_keep),
      .out_valid_o     (out_valid),
      .out_ready_i     (out_ready),
      .err_cnt_o       (err_cnt)
   );

   always #5 clk = ~clk;

   // FIFO read port: registered data one cycle after rd_en; also tracks pacing.
   always @(posedge clk) begin
      cyc++;
      if (fifo_rd_en === 1'b1) begin
         rd_cnt++;
         rd_times.push_back(cyc);
         if (cyc - last_rd < 4) spacing_viol++;
         last_rd = cyc;
         if (fifo_q.size() == 0) empty_reads++;
         else fifo_rdata <= fifo_q.pop_front();
      end
   end

   always @(negedge clk) fifo_empty = (fifo_q.size() == 0);

   // Output scoreboard: every transfer pops one expected {data, keep}.
   always @(negedge clk) begin
      logic [35:0] e;
      if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
         words_seen++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_word got data=%h keep=%h required no word", out_data, out_keep);
         end else begin
            e = exp_q.pop_front();
            if ({out_data, out_keep} !== e) begin
               errors++;
               $display("FAIL word got data=%h keep=%h required data=%h keep=%h",
                        out_data, out_keep, e[35:4], e[3:0]);
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_bytes(input logic [7:0] first, input int n);
      for (int i = 0; i < n; i++) fifo_q.push_back(8'(first + 8'(i)));
   endtask

   task automatic wait_drain(input int budget, input string name);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(posedge clk);
         n++;
      end
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_timeout got %0d words pending required 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      fifo_q.push_back(8'h5A);
      repeat (2) begin
         @(negedge clk);
         checks += 3;
         if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b required 0", fifo_rd_en); end
         if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b required 0", out_valid); end
         if (err_cnt !== 16'h0) begin errors++; $display("FAIL reset_err_cnt got %h required 0000", err_cnt); end
      end
      fifo_q.delete();
      tick(1);
      rst = 1'b0;
      tick(2);
   endtask

   task automatic test_pack();
      int rd0 = rd_cnt;
      rd_times.delete();
      out_ready = 1'b1;
      exp_q.push_back({32'h44332211, 4'hF});
      fifo_q.push_back(8'h11); fifo_q.push_back(8'h22);
      fifo_q.push_back(8'h33); fifo_q.push_back(8'h44);
      wait_drain(100, "pack");
      tick(4);
      checks++;
      if (rd_cnt - rd0 != 4) begin errors++; $display("FAIL pack_reads got %0d required 4", rd_cnt - rd0); end
      for (int i = 1; i < rd_times.size(); i++) begin
         checks++;
         if (rd_times[i] - rd_times[i-1] != 4) begin
            errors++;
            $display("FAIL pack_rd_gap got %0d required 4", rd_times[i] - rd_times[i-1]);
         end
      end
   endtask

   task automatic test_backpressure();
      int rd0 = rd_cnt;
      out_ready = 1'b0;
      exp_q.push_back({32'h04030201, 4'hF});
      exp_q.push_back({32'h08070605, 4'hF});
      exp_q.push_back({32'h0C0B0A09, 4'hF});
      push_bytes(8'h01, 12);
      tick(60);
      checks += 3;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid got %b required 1", out_valid); end
      if (out_data !== 32'h04030201) begin errors++; $display("FAIL bp_hold_a got %h required 04030201", out_data); end
      if (rd_cnt - rd0 != 8) begin errors++; $display("FAIL bp_reads got %0d required 8", rd_cnt - rd0); end
      tick(10);
      checks += 3;
      if (out_data !== 32'h04030201) begin errors++; $display("FAIL bp_hold_b got %h required 04030201", out_data); end
      if (out_keep !== 4'hF) begin errors++; $display("FAIL bp_keep got %h required f", out_keep); end
      if (fifo_q.size() != 4) begin errors++; $display("FAIL bp_fifo_left got %0d required 4", fifo_q.size()); end
      out_ready = 1'b1;
      wait_drain(200, "bp");
      tick(4);
   endtask

   task automatic test_flush();
      int w0;
      out_ready = 1'b1;
      fifo_q.push_back(8'hAA); fifo_q.push_back(8'hBB);
      tick(20);
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_early got %b required 0", out_valid); end
      exp_q.push_back({32'h0000BBAA, 4'h3});
      flush = 1'b1; tick(1); flush = 1'b0;
      wait_drain(50, "flush");
      tick(4);
      w0 = words_seen;
      flush = 1'b1; tick(1); flush = 1'b0;
      tick(20);
      checks += 2;
      if (words_seen != w0) begin errors++; $display("FAIL flush_empty_words got %0d required %0d", words_seen, w0); end
      if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_empty_valid got %b required 0", out_valid); end
   endtask

   task automatic test_empty_boundary();
      int rd0 = rd_cnt;
      tick(30);
      checks += 3;
      if (rd_cnt != rd0) begin errors++; $display("FAIL empty_reads_idle got %0d required %0d", rd_cnt, rd0); end
      if (empty_reads != 0) begin errors++; $display("FAIL empty_read_err got %0d required 0", empty_reads); end
      if (spacing_viol != 0) begin errors++; $display("FAIL rd_spacing got %0d required 0", spacing_viol); end
   endtask

   task automatic test_err_cnt();
      logic [15:0] exp_cnt;
`ifdef FIFO_RD_PACKER_ERR_CNT_EN
      exp_cnt = 16'd3;
`else
      exp_cnt = 16'd0;
`endif
      repeat (3) begin
         fifo_rd_error = 1'b1; tick(1);
         fifo_rd_error = 1'b0; tick(2);
      end
      checks++;
      if (err_cnt !== exp_cnt) begin errors++; $display("FAIL err_cnt got %h required %h", err_cnt, exp_cnt); end
      exp_q.push_back({32'hD3D2D1D0, 4'hF});
      push_bytes(8'hD0, 4);
      wait_drain(100, "err_then_pack");
      tick(4);
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b1;
      fifo_q.push_back(8'hE1); fifo_q.push_back(8'hE2);
      tick(20);
      rst = 1'b1; tick(2); rst = 1'b0;
      tick(1);
      checks++;
      if (err_cnt !== 16'h0) begin errors++; $display("FAIL mid_reset_err_cnt got %h required 0000", err_cnt); end
      exp_q.push_back({32'hF4F3F2F1, 4'hF});
      push_bytes(8'hF1, 4);
      wait_drain(100, "mid_reset");
      tick(10);
   endtask

   initial begin
      test_reset();
      test_pack();
      test_backpressure();
      test_flush();
      test_empty_boundary();
      test_err_cnt();
      test_reset_mid();
      test_empty_boundary();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
